fetch_prefetch_unit: RTL and testbench

- Instruction fetch stage feeding the single-cycle RV32I datapath.
- Fetches instruction words from a handshaked instruction memory with variable latency.
- Buffers fetched words with their word-addressed PC in a small prefetch FIFO.
- Presents instruction, PC and valid/ready to the execute stage; a redirect input (taken branch/jump) flushes stale work.

---
 rtl/fetch_prefetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - RV32I fetch stage with prefetch FIFO; FETCH_PERF_CNT_EN adds fetch/flush counters
module fetch_prefetch_unit #(
  parameter int N      = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [N-1:0]      redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [N-1:0]      mem_rdata,
  output logic              inst_valid,
  output logic [N-1:0]      inst,
  output logic [N-1:0]      inst_pc,
  input  logic              inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  fetch_pc;
  logic [N-1:0]  req_pc;
  logic [N-1:0]  fifo_inst [DEPTH];
  logic [N-1:0]  fifo_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          grant;
  logic          push;
  logic          pop;

  // At most one request in flight, and only when a FIFO slot is guaranteed for its response.
  assign mem_req    = (state == IDLE) && (count < DEPTH_C) && !redirect && !rst;
  assign mem_addr   = fetch_pc[ADDR_W-1:0];
  assign grant      = mem_req && mem_gnt;
  assign push       = (state == WAIT) && mem_rvalid && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign inst_valid = (count != '0);
  assign inst       = fifo_inst[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // Request FSM: a redirect while a response is pending parks in DRAIN to swallow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      if (state == WAIT || state == DRAIN) begin
        state <= mem_rvalid ? IDLE : DRAIN;
      end
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + N'(1);
            state    <= WAIT;
          end
        end
        WAIT:    if (mem_rvalid) state <= IDLE;
        DRAIN:   if (mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetch FIFO: power-of-2 depth so pointers wrap naturally; redirect flushes occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_inst[wr_ptr] <= mem_rdata;
        fifo_pc[wr_ptr]   <= req_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic discard;
  assign discard = mem_rvalid && ((state == DRAIN) || ((state == WAIT) && redirect));

  // Performance counters: pushes, and redirect cycles plus dropped responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + {31'd0, push};
      flush_cnt <= flush_cnt + {31'd0, redirect} + {31'd0, discard};
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        gnt_en;
  wire logic   mem_gnt = gnt_en;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int lat     = 1;
  int exp_pc;

  logic        busy = 1'b0;
  int          cnt  = 0;
  logic [15:0] paddr = 16'd0;

  fetch_prefetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h00500093 + (a << 7);
  endfunction

  // Memory model: response arrives lat cycles after the grant cycle.
  always @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      mem_rvalid <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= word_at({16'd0, paddr});
          busy       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (mem_req && mem_gnt) begin
        if (lat <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= word_at({16'd0, mem_addr});
        end else begin
          busy  <= 1'b1;
          cnt   <= lat - 1;
          paddr <= mem_addr;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    gnt_en = 1'b1; inst_ready = 1'b0; lat = 1;

    // Reset state and first fetch
    step(2);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
    rst = 1'b0;
    #1;
    chk("first_req", {63'd0, mem_req}, 64'd1);
    chk("first_addr", {48'd0, mem_addr}, 64'd0);
    step(1);
    chk("wait_no_valid", {63'd0, inst_valid}, 64'd0);
    chk("wait_no_req", {63'd0, mem_req}, 64'd0);
    step(1);
    chk("first_valid", {63'd0, inst_valid}, 64'd1);
    chk("first_inst", {32'd0, inst}, 64'h00500093);
    chk("first_pc", {32'd0, inst_pc}, 64'd0);
    chk("second_addr", {48'd0, mem_addr}, 64'd1);

    // Streaming: one instruction every 2 cycles, in order
    inst_ready = 1'b1;
    exp_pc = 0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin
        chk("stream_pc", {32'd0, inst_pc}, 64'(exp_pc));
        chk("stream_inst", {32'd0, inst}, {32'd0, word_at(32'(exp_pc))});
        exp_pc++;
      end
      step(1);
    end
    chk("stream_count", 64'(exp_pc), 64'd10);

    // Backpressure: fill to DEPTH, then a single pop re-enables fetch
    rst = 1'b1; inst_ready = 1'b0;
    step(1);
    rst = 1'b0;
    step(10);
    chk("full_valid", {63'd0, inst_valid}, 64'd1);
    chk("full_head_pc", {32'd0, inst_pc}, 64'd0);
    chk("full_no_req", {63'd0, mem_req}, 64'd0);
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0;
    #1;
    chk("refill_req", {63'd0, mem_req}, 64'd1);
    chk("refill_addr", {48'd0, mem_addr}, 64'd4);
    chk("after_pop_pc", {32'd0, inst_pc}, 64'd1);
    inst_ready = 1'b1;
    exp_pc = 1;
    for (int i = 0; i < 12; i++) begin
      if (inst_valid) begin
        chk("wrap_pc", {32'd0, inst_pc}, 64'(exp_pc));
        exp_pc++;
      end
      step(1);
    end
    chk("wrap_count", 64'(exp_pc), 64'd9);

    // Redirect while a 3-cycle response is pending
    rst = 1'b1; lat = 3;
    step(1);
    rst = 1'b0;
    step(1);
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("redir_req_low", {63'd0, mem_req}, 64'd0);
    step(1);
    redirect = 1'b0;
    #1;
    chk("drain_no_req", {63'd0, mem_req}, 64'd0);
    step(1);
    chk("drain_no_req2", {63'd0, mem_req}, 64'd0);
    step(1);
    chk("late_not_pushed", {63'd0, inst_valid}, 64'd0);
    chk("redir_req", {63'd0, mem_req}, 64'd1);
    chk("redir_addr", {48'd0, mem_addr}, 64'h40);
    step(4);
    chk("redir_valid", {63'd0, inst_valid}, 64'd1);
    chk("redir_pc", {32'd0, inst_pc}, 64'h40);
    chk("redir_inst", {32'd0, inst}, {32'd0, word_at(32'h40)});

    // Redirect in the same cycle as the response
    lat = 1;
    step(1);
    redirect = 1'b1; redirect_pc = 32'h100;
    step(1);
    redirect = 1'b0; inst_ready = 1'b0;
    #1;
    chk("rv_redir_no_push", {63'd0, inst_valid}, 64'd0);
    chk("rv_redir_addr", {48'd0, mem_addr}, 64'h100);
    chk("rv_redir_req", {63'd0, mem_req}, 64'd1);

    // Redirect while full with inst_ready high
    step(10);
    chk("full2_valid", {63'd0, inst_valid}, 64'd1);
    chk("full2_pc", {32'd0, inst_pc}, 64'h100);
    chk("full2_no_req", {63'd0, mem_req}, 64'd0);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step(1);
    redirect = 1'b0; inst_ready = 1'b0;
    #1;
    chk("flush_empty", {63'd0, inst_valid}, 64'd0);
    chk("flush_addr", {48'd0, mem_addr}, 64'h200);
    step(2);
    chk("flush_new_pc", {32'd0, inst_pc}, 64'h200);

`ifdef FETCH_PERF_CNT_EN
    // Performance counters
    rst = 1'b1; inst_ready = 1'b1; lat = 1;
    step(1);
    rst = 1'b0;
    step(10);
    lat = 3;
    step(1);
    redirect = 1'b1; redirect_pc = 32'h80;
    step(1);
    redirect = 1'b0;
    step(2);
    chk("fetch_cnt", {32'd0, fetch_cnt}, 64'd5);
    chk("flush_cnt", {32'd0, flush_cnt}, 64'd2);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("fetch_cnt_rst", {32'd0, fetch_cnt}, 64'd0);
    chk("flush_cnt_rst", {32'd0, flush_cnt}, 64'd0);
    #1;
    chk("cnt_rst_addr", {48'd0, mem_addr}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
